// File: rtl/siso_pkg.sv
// siso_pkg: shared constants and helpers for the serial-in serial-out register.
//   RST_ACTIVE - level of rst that clears the register (active-low)
//   fill_cnt_w - bit width of a counter able to hold 0..width
package siso_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int fill_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/siso_stage.sv
// siso_stage: one D flip-flop stage with asynchronous active-low clear.
//   clk - rising-edge clock
//   rst - asynchronous clear, active-low
//   d   - stage input
//   q   - registered stage output
module siso_stage
    import siso_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic bit_d;
    logic bit_q;

    always_comb bit_d = d;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) bit_q <= 1'b0;
        else                   bit_q <= bit_d;
    end

    assign q = bit_q;

endmodule

// File: rtl/siso_register.sv
// siso_register: WIDTH-stage serial-in serial-out shift register with fill flag.
//   clk          - rising-edge clock
//   rst          - asynchronous reset, active-low
//   serial_in    - bit sampled every rising edge
//   serial_out   - oldest stage, WIDTH edges after sampling
//   parallel_out - all stages, bit 0 newest, bit WIDTH-1 oldest
//   fill_valid   - high once WIDTH shifts have happened since reset release
module siso_register
    import siso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic             fill_valid
);

    localparam int            CW   = fill_cnt_w(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("siso_register: WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] stage;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            siso_stage u_stage (.clk(clk), .rst(rst), .d(serial_in), .q(stage[0]));
        end else begin : g_body
            siso_stage u_stage (.clk(clk), .rst(rst), .d(stage[i-1]), .q(stage[i]));
        end
    end

    // Counter holds at WIDTH so fill_valid stays high until the next reset.
    always_comb cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) cnt_q <= '0;
        else                   cnt_q <= cnt_d;
    end

    assign serial_out   = stage[WIDTH-1];
    assign parallel_out = stage;
    assign fill_valid   = (cnt_q == FULL);

endmodule

// File: tb/tb_siso_register.sv
// tb_siso_register: randomized self-checking bench for siso_register (WIDTH 4 and 1).
module tb_siso_register;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       si4 = 1'b0;
    logic       si1 = 1'b0;
    logic       so4, so1, fv4, fv1;
    logic [3:0] po4;
    logic [0:0] po1;

    int checks   = 0;
    int failures = 0;

    bit h4[$];
    bit h1[$];

    siso_register #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .serial_in(si4),
        .serial_out(so4), .parallel_out(po4), .fill_valid(fv4)
    );

    siso_register #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .serial_in(si1),
        .serial_out(so1), .parallel_out(po1), .fill_valid(fv1)
    );

    always #5 clk = ~clk;

    // Reference: history of bits accepted since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h4.delete();
            h1.delete();
        end else begin
            h4.push_back(si4);
            h1.push_back(si1);
        end
    end

    // Bit j of the expected stage view is the sample taken j edges ago, zero if none yet.
    function automatic logic [31:0] model_par(input bit q[$], input int w);
        logic [31:0] r = '0;
        for (int j = 0; j < w; j++)
            if (q.size() - 1 - j >= 0) r[j] = q[q.size() - 1 - j];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_w4();
        logic [31:0] e;
        e = model_par(h4, 4);
        check("w4_par", 32'(po4), e);
        check("w4_sout", 32'(so4), 32'(e[3]));
        check("w4_fill", 32'(fv4), 32'(h4.size() >= 4));
    endtask

    task automatic step(input bit b);
        @(negedge clk);
        check_w4();
        si4 = b;
    endtask

    // WIDTH=1 instance: checked and re-driven every falling edge for the whole run.
    initial begin
        forever begin
            @(negedge clk);
            check("w1_sout", 32'(so1), 32'(h1.size() >= 1 ? h1[h1.size() - 1] : 1'b0));
            check("w1_par", 32'(po1), model_par(h1, 1));
            check("w1_fill", 32'(fv1), 32'(h1.size() >= 1));
            si1 = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [3:0] walk [5];
        bit         pat  [6];
        logic       rso  [7];
        walk = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        pat  = '{1, 0, 1, 1, 1, 0};
        rso  = '{0, 0, 0, 1, 1, 0, 0};

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_sout", 32'(so4), 32'd0);
            check("rst_par", 32'(po4), 32'd0);
            check("rst_fill", 32'(fv4), 32'd0);
            si4 = ~si4;
        end

        @(negedge clk);
        rst = 1'b1;
        si4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("pulse_par", 32'(po4), 32'(walk[k]));
            check("pulse_sout", 32'(so4), 32'(k == 3));
            check("pulse_fill", 32'(fv4), 32'(k >= 3));
            si4 = 1'b0;
        end

        foreach (pat[k]) step(pat[k]);
        for (int k = 0; k < 6; k++) step(1'b0);

        for (int k = 0; k < 3; k++) step(1'b1);
        @(negedge clk);
        check_w4();
        #2 rst = 1'b0;
        #1;
        check("mid_par", 32'(po4), 32'd0);
        check("mid_sout", 32'(so4), 32'd0);
        check("mid_fill", 32'(fv4), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        si4 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("rel_sout", 32'(so4), 32'(rso[k]));
            check_w4();
            si4 = (k == 0) ? 1'b1 : 1'b0;
        end

        for (int k = 0; k < 20; k++) begin
            step(1'($urandom_range(0, 1)));
            check("sat_fill", 32'(fv4), 32'd1);
        end
        step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
